// File: rtl/hpdcache_mem_write_req_arbiter_pkg.sv
// Shared types for the memory write-request arbiter.
package hpdcache_mem_write_req_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/hpdcache_mem_write_req_arbiter_if.sv
// Request + multi-beat write-data channel bundle, N lanes wide.
// master drives valid/payload, slave drives ready; the memory side uses N=1.
interface hpdcache_mem_write_req_arbiter_if #(
    parameter int unsigned N = 2,
    parameter type hpdcache_mem_req_t = logic,
    parameter type hpdcache_mem_req_w_t = logic
);
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    hpdcache_mem_req_t   req [N];
    logic [N-1:0]        req_wdata;
    logic [N-1:0]        data_valid;
    logic [N-1:0]        data_ready;
    hpdcache_mem_req_w_t data [N];
    logic [N-1:0]        data_last;

    modport master (
        output req_valid, req, req_wdata, data_valid, data, data_last,
        input  req_ready, data_ready
    );

    modport slave (
        input  req_valid, req, req_wdata, data_valid, data, data_last,
        output req_ready, data_ready
    );
endinterface

// File: rtl/hpdcache_mux.sv
// Generic payload multiplexer; one-hot select (OR of gated inputs) or binary index.
module hpdcache_mux #(
    parameter int unsigned NINPUTS = 2,
    parameter type data_t = logic,
    parameter bit ONE_HOT_SEL = 1'b0,
    localparam int unsigned SEL_W = ONE_HOT_SEL ? NINPUTS
                                                : ((NINPUTS > 1) ? $clog2(NINPUTS) : 1)
) (
    input  logic [SEL_W-1:0] sel_i,
    input  data_t            data_i [NINPUTS],
    output data_t            data_o
);

    generate
        if (ONE_HOT_SEL) begin : gen_onehot
            // An all-zero select yields zero, which keeps idle outputs quiet.
            always_comb begin
                data_o = '0;
                for (int i = 0; i < NINPUTS; i++) begin
                    if (sel_i[i]) data_o = data_o | data_i[i];
                end
            end
        end else begin : gen_binary
            assign data_o = data_i[sel_i];
        end
    endgenerate

endmodule

// File: rtl/hpdcache_rrarb.sv
// Round-robin arbiter with one-hot grant; only built with HPDCACHE_MEM_WRITE_ARB_RR_EN.
`ifdef HPDCACHE_MEM_WRITE_ARB_RR_EN
module hpdcache_rrarb #(
    parameter int unsigned N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         upd_i,
    input  logic [N-1:0] upd_gnt_i,
    output logic [N-1:0] gnt_o
);

    // The pointer is held as a mask of eligible-first requesters (bit i set when i >= ptr);
    // all ones is pointer 0.
    logic [N-1:0] mask_q, mask_d;
    logic [N-1:0] masked_req, pick_from;
    logic         seen;

    assign masked_req = req_i & mask_q;
    assign pick_from  = (|masked_req) ? masked_req : req_i;

    always_comb begin
        gnt_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick_from[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
    end

    // Next pointer is the requester after the winner; past N-1 it wraps to 0 (all ones).
    always_comb begin
        mask_d = mask_q;
        seen   = 1'b0;
        if (upd_i) begin
            for (int i = 0; i < N; i++) begin
                mask_d[i] = seen;
                seen      = seen | upd_gnt_i[i];
            end
            if (mask_d == '0) mask_d = '1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) mask_q <= '1;
        else         mask_q <= mask_d;
    end

endmodule
`endif

// File: rtl/hpdcache_mem_write_req_arbiter.sv
// Grants the memory request + write-data channels to one of N requesters per transaction.
// Define HPDCACHE_MEM_WRITE_ARB_RR_EN for round-robin; otherwise lowest index wins.
module hpdcache_mem_write_req_arbiter
    import hpdcache_mem_write_req_arbiter_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter type hpdcache_mem_req_t = logic,
    parameter type hpdcache_mem_req_w_t = logic
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    hpdcache_mem_write_req_arbiter_if.slave         arb,
    hpdcache_mem_write_req_arbiter_if.master        mem,
    output logic [N-1:0]                            gnt_o
);

    arb_state_e   state_q, state_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [N-1:0] arb_gnt;
    logic         req_done_q, req_done_d;
    logic         data_done_q, data_done_d;
    logic         mem_req_valid, mem_data_valid, mem_data_last;
    logic [N-1:0] arb_req_ready, arb_data_ready;
    logic         req_fin, data_fin;

`ifdef HPDCACHE_MEM_WRITE_ARB_RR_EN
    logic ptr_upd;

    assign ptr_upd = (state_q == ARB_XFER) & req_fin & data_fin;

    hpdcache_rrarb #(
        .N (N)
    ) rrarb_i (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (arb.req_valid),
        .upd_i     (ptr_upd),
        .upd_gnt_i (gnt_q),
        .gnt_o     (arb_gnt)
    );
`else
    always_comb begin
        arb_gnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (arb.req_valid[i]) begin
                arb_gnt    = '0;
                arb_gnt[i] = 1'b1;
            end
        end
    end
`endif

    // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        req_done_d     = req_done_q;
        data_done_d    = data_done_q;
        mem_req_valid  = 1'b0;
        mem_data_valid = 1'b0;
        arb_req_ready  = '0;
        arb_data_ready = '0;
        req_fin        = 1'b0;
        data_fin       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (|arb.req_valid) begin
                    state_d     = ARB_XFER;
                    gnt_d       = arb_gnt;
                    req_done_d  = 1'b0;
                    // A request without write data has no data phase to wait for.
                    data_done_d = ~|(arb_gnt & arb.req_wdata);
                end
            end

            ARB_XFER: begin
                mem_req_valid  = |(gnt_q & arb.req_valid) & ~req_done_q;
                mem_data_valid = |(gnt_q & arb.data_valid) & ~data_done_q;
                arb_req_ready  = gnt_q & {N{mem.req_ready[0] & ~req_done_q}};
                arb_data_ready = gnt_q & {N{mem.data_ready[0] & ~data_done_q}};

                req_fin  = req_done_q | (mem_req_valid & mem.req_ready[0]);
                data_fin = data_done_q | (mem_data_valid & mem.data_ready[0] & mem_data_last);

                req_done_d  = req_fin;
                data_done_d = data_fin;

                if (req_fin & data_fin) begin
                    state_d     = ARB_IDLE;
                    gnt_d       = '0;
                    req_done_d  = 1'b0;
                    data_done_d = 1'b0;
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            req_done_q  <= 1'b0;
            data_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            req_done_q  <= req_done_d;
            data_done_q <= data_done_d;
        end
    end

    hpdcache_mux #(
        .NINPUTS     (N),
        .data_t      (hpdcache_mem_req_t),
        .ONE_HOT_SEL (1'b1)
    ) req_mux_i (
        .sel_i  (gnt_q),
        .data_i (arb.req),
        .data_o (mem.req[0])
    );

    hpdcache_mux #(
        .NINPUTS     (N),
        .data_t      (hpdcache_mem_req_w_t),
        .ONE_HOT_SEL (1'b1)
    ) data_mux_i (
        .sel_i  (gnt_q),
        .data_i (arb.data),
        .data_o (mem.data[0])
    );

    assign mem_data_last   = |(gnt_q & arb.data_last);
    assign mem.req_wdata   = |(gnt_q & arb.req_wdata);
    assign mem.req_valid   = mem_req_valid;
    assign mem.data_valid  = mem_data_valid;
    assign mem.data_last   = mem_data_last;
    assign arb.req_ready   = arb_req_ready;
    assign arb.data_ready  = arb_data_ready;
    assign gnt_o           = gnt_q;

endmodule

// File: tb/tb_hpdcache_mem_write_req_arbiter.sv
// Directed bench for hpdcache_mem_write_req_arbiter with four requesters.
module tb_hpdcache_mem_write_req_arbiter;

    typedef logic [15:0] req_t;
    typedef logic [31:0] wdat_t;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] gnt_o;
    int         checks = 0;
    int         errors = 0;

    always #5 clk_i = ~clk_i;

    hpdcache_mem_write_req_arbiter_if #(
        .N(4), .hpdcache_mem_req_t(req_t), .hpdcache_mem_req_w_t(wdat_t)
    ) arb_if ();

    hpdcache_mem_write_req_arbiter_if #(
        .N(1), .hpdcache_mem_req_t(req_t), .hpdcache_mem_req_w_t(wdat_t)
    ) mem_if ();

    hpdcache_mem_write_req_arbiter #(
        .N(4), .hpdcache_mem_req_t(req_t), .hpdcache_mem_req_w_t(wdat_t)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .arb    (arb_if),
        .mem    (mem_if),
        .gnt_o  (gnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        arb_if.req_valid  = '0;
        arb_if.req_wdata  = '0;
        arb_if.data_valid = '0;
        arb_if.data_last  = '0;
        for (int i = 0; i < 4; i++) begin
            arb_if.req[i]  = '0;
            arb_if.data[i] = '0;
        end
        mem_if.req_ready  = 1'b1;
        mem_if.data_ready = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    int         cnt1, cnt3, n_gnt;
    logic [3:0] prev_gnt;
    logic [3:0] order [4];
    logic       hs1, hs3;

    initial begin
        // Reset state
        clear_inputs();
        rst_ni = 1'b0;
        mid();
        check("rst_gnt", 32'(gnt_o), 0);
        check("rst_mem_req_valid", 32'(mem_if.req_valid), 0);
        check("rst_mem_data_valid", 32'(mem_if.data_valid), 0);
        check("rst_arb_req_ready", 32'(arb_if.req_ready), 0);
        mid();
        rst_ni = 1'b1;

        // 1: req0 writes 3 beats, data offered two cycles before the request
        cyc();
        arb_if.data_valid[0] = 1'b1; arb_if.data[0] = 32'hD000_0000; arb_if.data_last[0] = 1'b0;
        mid();
        check("t1_idle_data_ready", 32'(arb_if.data_ready), 0);
        check("t1_idle_mem_data_valid", 32'(mem_if.data_valid), 0);
        cyc();
        cyc();
        arb_if.req_valid[0] = 1'b1; arb_if.req[0] = 16'h1000; arb_if.req_wdata[0] = 1'b1;
        mid();
        check("t1_arb_cycle_gnt", 32'(gnt_o), 0);
        cyc();
        mid();
        check("t1_gnt", 32'(gnt_o), 32'h1);
        check("t1_mem_req_valid", 32'(mem_if.req_valid), 1);
        check("t1_mem_req", 32'(mem_if.req[0]), 32'h1000);
        check("t1_mem_wdata", 32'(mem_if.req_wdata), 1);
        check("t1_beat0", 32'(mem_if.data[0]), 32'hD000_0000);
        check("t1_beat0_last", 32'(mem_if.data_last), 0);
        check("t1_req_ready", 32'(arb_if.req_ready), 32'h1);
        check("t1_data_ready", 32'(arb_if.data_ready), 32'h1);
        cyc();
        arb_if.req_valid[0] = 1'b0; arb_if.data[0] = 32'hD000_0001;
        mid();
        check("t1_req_done_valid", 32'(mem_if.req_valid), 0);
        check("t1_req_done_ready", 32'(arb_if.req_ready), 0);
        check("t1_beat1", 32'(mem_if.data[0]), 32'hD000_0001);
        check("t1_beat1_valid", 32'(mem_if.data_valid), 1);
        cyc();
        arb_if.data[0] = 32'hD000_0002; arb_if.data_last[0] = 1'b1;
        mid();
        check("t1_beat2", 32'(mem_if.data[0]), 32'hD000_0002);
        check("t1_beat2_last", 32'(mem_if.data_last), 1);
        check("t1_gnt_held", 32'(gnt_o), 32'h1);
        cyc();
        arb_if.data_valid[0] = 1'b0; arb_if.data_last[0] = 1'b0;
        mid();
        check("t1_idle_gnt", 32'(gnt_o), 0);
        check("t1_idle_data_valid", 32'(mem_if.data_valid), 0);

        // 2: req2 without write data; a stray data valid must not leak through
        cyc();
        arb_if.req_valid[2] = 1'b1; arb_if.req[2] = 16'h2222; arb_if.req_wdata[2] = 1'b0;
        mid();
        check("t2_arb_cycle_gnt", 32'(gnt_o), 0);
        cyc();
        arb_if.data_valid[2] = 1'b1; arb_if.data[2] = 32'hBAD0_BAD0;
        mid();
        check("t2_gnt", 32'(gnt_o), 32'h4);
        check("t2_mem_req_valid", 32'(mem_if.req_valid), 1);
        check("t2_mem_req", 32'(mem_if.req[0]), 32'h2222);
        check("t2_mem_wdata", 32'(mem_if.req_wdata), 0);
        check("t2_no_data_valid", 32'(mem_if.data_valid), 0);
        check("t2_no_data_ready", 32'(arb_if.data_ready), 0);
        cyc();
        arb_if.req_valid[2] = 1'b0; arb_if.data_valid[2] = 1'b0;
        mid();
        check("t2_gnt_cleared", 32'(gnt_o), 0);
        check("t2_idle_req_valid", 32'(mem_if.req_valid), 0);

        // 3: req1 and req3 each issue two data-less requests
        do_reset();
        arb_if.req_valid[1] = 1'b1; arb_if.req[1] = 16'h3131;
        arb_if.req_valid[3] = 1'b1; arb_if.req[3] = 16'h3333;
        cnt1 = 2; cnt3 = 2; n_gnt = 0; prev_gnt = '0;
        for (int c = 0; c < 40 && (cnt1 + cnt3) > 0; c++) begin
            mid();
            if (gnt_o != 4'b0 && prev_gnt == 4'b0 && n_gnt < 4) begin
                order[n_gnt] = gnt_o;
                n_gnt++;
            end
            prev_gnt = gnt_o;
            hs1 = arb_if.req_ready[1] & arb_if.req_valid[1];
            hs3 = arb_if.req_ready[3] & arb_if.req_valid[3];
            cyc();
            if (hs1) begin cnt1--; if (cnt1 == 0) arb_if.req_valid[1] = 1'b0; end
            if (hs3) begin cnt3--; if (cnt3 == 0) arb_if.req_valid[3] = 1'b0; end
        end
        check("t3_all_done", 32'(cnt1 + cnt3), 0);
        check("t3_grant_count", 32'(n_gnt), 4);
`ifdef HPDCACHE_MEM_WRITE_ARB_RR_EN
        check("t3_order0", 32'(order[0]), 32'h2);
        check("t3_order1", 32'(order[1]), 32'h8);
        check("t3_order2", 32'(order[2]), 32'h2);
        check("t3_order3", 32'(order[3]), 32'h8);
`else
        check("t3_order0", 32'(order[0]), 32'h2);
        check("t3_order1", 32'(order[1]), 32'h2);
        check("t3_order2", 32'(order[2]), 32'h8);
        check("t3_order3", 32'(order[3]), 32'h8);
`endif

        // 4: memory holds off the request for 5 cycles
        mem_if.req_ready = 1'b0;
        cyc();
        arb_if.req_valid[0] = 1'b1; arb_if.req[0] = 16'h4444; arb_if.req_wdata[0] = 1'b1;
        arb_if.data_valid[0] = 1'b1; arb_if.data[0] = 32'hD444_0000; arb_if.data_last[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (k == 1) begin arb_if.data_valid[0] = 1'b0; arb_if.data_last[0] = 1'b0; end
            mid();
            if (k == 0) check("t4_single_beat_last", 32'(mem_if.data_last), 1);
            check("t4_req_valid_held", 32'(mem_if.req_valid), 1);
            check("t4_req_stable", 32'(mem_if.req[0]), 32'h4444);
            check("t4_req_ready_low", 32'(arb_if.req_ready), 0);
        end
        cyc();
        mem_if.req_ready = 1'b1;
        mid();
        check("t4_req_accept", 32'(arb_if.req_ready), 32'h1);
        check("t4_gnt", 32'(gnt_o), 32'h1);
        cyc();
        arb_if.req_valid[0] = 1'b0;
        mid();
        check("t4_idle_gnt", 32'(gnt_o), 0);

        // 5: request and last beat complete together; req3 waits
        mem_if.req_ready = 1'b0;
        cyc();
        arb_if.req_valid[1] = 1'b1; arb_if.req[1] = 16'h5151; arb_if.req_wdata[1] = 1'b1;
        arb_if.data_valid[1] = 1'b1; arb_if.data[1] = 32'hD555_0000; arb_if.data_last[1] = 1'b0;
        arb_if.req_valid[3] = 1'b1; arb_if.req[3] = 16'h5353; arb_if.req_wdata[3] = 1'b0;
        cyc();
        mid();
        check("t5_gnt", 32'(gnt_o), 32'h2);
        check("t5_req_blocked", 32'(arb_if.req_ready), 0);
        cyc();
        arb_if.data[1] = 32'hD555_0001; arb_if.data_last[1] = 1'b1; mem_if.req_ready = 1'b1;
        mid();
        check("t5_joint_req_ready", 32'(arb_if.req_ready), 32'h2);
        check("t5_joint_data_ready", 32'(arb_if.data_ready), 32'h2);
        check("t5_joint_last", 32'(mem_if.data_last), 1);
        cyc();
        arb_if.req_valid[1] = 1'b0; arb_if.data_valid[1] = 1'b0; arb_if.data_last[1] = 1'b0;
        mid();
        check("t5_idle_gnt", 32'(gnt_o), 0);
        check("t5_idle_req_valid", 32'(mem_if.req_valid), 0);
        cyc();
        mid();
        check("t5_next_gnt", 32'(gnt_o), 32'h8);
        check("t5_next_req", 32'(mem_if.req[0]), 32'h5353);
        cyc();
        arb_if.req_valid[3] = 1'b0;
        mid();
        check("t5_final_idle", 32'(gnt_o), 0);

        // 6: asynchronous reset in the middle of a 4-beat burst
        cyc();
        arb_if.req_valid[0] = 1'b1; arb_if.req[0] = 16'h6060; arb_if.req_wdata[0] = 1'b1;
        arb_if.data_valid[0] = 1'b1; arb_if.data[0] = 32'hD666_0000; arb_if.data_last[0] = 1'b0;
        cyc();
        cyc();
        arb_if.req_valid[0] = 1'b0; arb_if.data[0] = 32'hD666_0001;
        cyc();
        arb_if.data[0] = 32'hD666_0002;
        mid();
        check("t6_beat3_valid", 32'(mem_if.data_valid), 1);
        check("t6_beat3_data", 32'(mem_if.data[0]), 32'hD666_0002);
        #1 rst_ni = 1'b0;
        #1;
        check("t6_rst_gnt", 32'(gnt_o), 0);
        check("t6_rst_data_valid", 32'(mem_if.data_valid), 0);
        check("t6_rst_data_ready", 32'(arb_if.data_ready), 0);
        check("t6_rst_req_valid", 32'(mem_if.req_valid), 0);
        arb_if.data_valid[0] = 1'b0; arb_if.req_wdata[0] = 1'b0;
        arb_if.req_valid[0] = 1'b1; arb_if.req[0] = 16'h6161;
        cyc();
        cyc();
        mid();
        rst_ni = 1'b1;
        #1;
        check("t6_release_gnt", 32'(gnt_o), 0);
        cyc();
        mid();
        check("t6_regrant", 32'(gnt_o), 32'h1);
        check("t6_regrant_req", 32'(mem_if.req[0]), 32'h6161);
        cyc();
        arb_if.req_valid[0] = 1'b0;
        mid();
        check("t6_final_idle", 32'(gnt_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
